bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), producing packed BCD digits from an unsigned binary word. It is the producer side of the BCD datapath: its output feeds the BCD adders and display logic that consume packed BCD nibbles. A conversion is started with a one-cycle `start` pulse and takes one clock per input bit.

---
 rtl/bin_to_bcd_seq_if.sv | 21 ++
 rtl/bin_to_bcd_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/operand/result bundle for the sequential binary-to-BCD converter
// The ovf member exists only when BIN2BCD_OVF_EN is defined.
interface bin_to_bcd_seq_if #(
   parameter int W      = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [W-1:0]          bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_OVF_EN
   logic                  ovf;

   modport master (output start, output bin, input busy, input done, input bcd, input ovf);
   modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
`else
   modport master (output start, output bin, input busy, input done, input bcd);
   modport slave  (input start, input bin, output busy, output done, output bcd);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - shift-and-add-3 binary-to-BCD converter, one clock per input bit
// Optional overflow flag and reduced DIGITS enabled by macro BIN2BCD_OVF_EN.
module bin_to_bcd_seq #(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic               clk,
   input  logic               nrst,
   bin_to_bcd_seq_if.slave    io
);
   localparam int SRW = 4*DIGITS + W;
   localparam int CW  = $clog2(W + 1);

   // Decimal digits needed for the largest W-bit value.
   function automatic int min_digits(input int w);
      longint unsigned v;
      int              d;
      v = (64'd1 << w) - 64'd1;
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
         end
      end
      return d;
   endfunction

   if (W < 1 || W > 32) begin : g_width_range
      $error("bin_to_bcd_seq: W must be 1..32");
   end
`ifndef BIN2BCD_OVF_EN
   if (DIGITS < min_digits(W)) begin : g_digits_too_small
      $error("bin_to_bcd_seq: DIGITS too small for W without overflow support");
   end
`endif

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [SRW-1:0]        sr;
   logic [SRW-1:0]        adj;
   logic [SRW-1:0]        sr_nxt;
   logic [CW-1:0]         cnt;
   logic                  last;
   logic                  done_q;
   logic [4*DIGITS-1:0]   bcd_q;

   always_comb begin
      adj = sr;
      for (int k = 0; k < DIGITS; k++) begin
         if (sr[W+4*k +: 4] >= 4'd5) begin
            adj[W+4*k +: 4] = sr[W+4*k +: 4] + 4'd3;
         end
      end
      sr_nxt = adj << 1;
   end

   assign last = (state == SHIFT) && (cnt == CW'(1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.start) state_nxt = SHIFT;
         SHIFT:   if (last)     state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sr     <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         bcd_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (io.start) begin
               sr  <= {{(4*DIGITS){1'b0}}, io.bin};
               cnt <= CW'(W);
            end
         end else begin
            sr  <= sr_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
               bcd_q  <= sr_nxt[SRW-1 -: 4*DIGITS];
               done_q <= 1'b1;
            end
         end
      end
   end

`ifdef BIN2BCD_OVF_EN
   logic ovf_sticky;
   logic ovf_q;

   // The bit leaving the top digit is the adjusted MSB before the shift.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ovf_sticky <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (state == IDLE) begin
         if (io.start) ovf_sticky <= 1'b0;
      end else begin
         if (adj[SRW-1]) ovf_sticky <= 1'b1;
         if (last)       ovf_q      <= ovf_sticky | adj[SRW-1];
      end
   end

   assign io.ovf = ovf_q;
`endif

   assign io.busy = (state == SHIFT);
   assign io.done = done_q;
   assign io.bcd  = bcd_q;
endmodule
